// File: rtl/bcrypt_cmp_apply_ctrl_if.sv
// Handshake bundle between the config-apply controller, the pkt_comm dispatcher,
// the result path and the cmp_config parser.
interface bcrypt_cmp_apply_ctrl_if #(
  parameter int CNT_W = 6
);
  logic             new_cmp_config;
  logic             cmp_config_applied;
  logic             job_issue;
  logic             job_done;
  logic             result_empty;
  logic             issue_allow;
  logic             cfg_load;
  logic [7:0]       cfg_epoch;
  logic             busy;
  logic [CNT_W-1:0] outstanding;
  logic             error;

  modport master (
    input  new_cmp_config, job_issue, job_done, result_empty,
    output cmp_config_applied, issue_allow, cfg_load, cfg_epoch, busy, outstanding, error
  );

  modport slave (
    output new_cmp_config, job_issue, job_done, result_empty,
    input  cmp_config_applied, issue_allow, cfg_load, cfg_epoch, busy, outstanding, error
  );
endinterface

// File: rtl/bcrypt_cmp_apply_ctrl.sv
// Drains in-flight bcrypt jobs before a comparator config change, strobes
// cfg_load to the cores, then acknowledges the parser with cmp_config_applied.
module bcrypt_cmp_apply_ctrl #(
  parameter int CNT_W         = 6,
  parameter int LOAD_CYCLES   = 4,
  parameter int DRAIN_TIMEOUT = 65535
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  bcrypt_cmp_apply_ctrl_if.master  bus
);
  localparam int TMO_W = (DRAIN_TIMEOUT > 1) ? $clog2(DRAIN_TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'((DRAIN_TIMEOUT > 0) ? DRAIN_TIMEOUT - 1 : 0);
  localparam logic [3:0]       LOAD_LAST = 4'(LOAD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  typedef enum logic [2:0] {IDLE_RST, RUN, DRAIN, LOAD, ACK, WAIT_LOW, FAULT} state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TMO_W-1:0] tmo_q;
  logic [3:0]       load_q;
  logic [7:0]       epoch_q;
  logic             applied_q, issue_q, cfg_load_q, busy_q, error_q;
  logic             cnt_err, drain_ok, tmo_hit, fault_d;

  // Counter saturates at both ends; an over/underflow attempt is a fault.
  always_comb begin
    cnt_d   = cnt_q;
    cnt_err = 1'b0;
    case ({bus.job_issue, bus.job_done})
      2'b10:   if (cnt_q == CNT_MAX) cnt_err = 1'b1; else cnt_d = cnt_q + 1'b1;
      2'b01:   if (cnt_q == '0)      cnt_err = 1'b1; else cnt_d = cnt_q - 1'b1;
      default: ;
    endcase
    drain_ok = (cnt_q == '0) && bus.result_empty;
    tmo_hit  = (DRAIN_TIMEOUT != 0) && (tmo_q == TMO_LAST);
    fault_d  = cnt_err || ((state_q == DRAIN) && (bus.job_issue || (tmo_hit && !drain_ok)));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE_RST;
      cnt_q      <= '0;
      tmo_q      <= '0;
      load_q     <= '0;
      epoch_q    <= '0;
      applied_q  <= 1'b0;
      issue_q    <= 1'b0;
      cfg_load_q <= 1'b0;
      busy_q     <= 1'b1;
      error_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      applied_q <= 1'b0;
      // A fault overrides any pending transition, so a load cut short never acks.
      if (fault_d || state_q == FAULT) begin
        state_q    <= FAULT;
        error_q    <= 1'b1;
        issue_q    <= 1'b0;
        cfg_load_q <= 1'b0;
        busy_q     <= 1'b1;
      end else begin
        case (state_q)
          IDLE_RST: begin
            state_q <= RUN;
            issue_q <= ~bus.new_cmp_config;
            busy_q  <= 1'b0;
          end
          RUN: begin
            if (bus.new_cmp_config) begin
              state_q <= DRAIN;
              issue_q <= 1'b0;
              busy_q  <= 1'b1;
              tmo_q   <= '0;
            end else begin
              issue_q <= 1'b1;
            end
          end
          DRAIN: begin
            if (drain_ok) begin
              state_q    <= LOAD;
              cfg_load_q <= 1'b1;
              load_q     <= '0;
            end else begin
              tmo_q <= tmo_q + 1'b1;
            end
          end
          LOAD: begin
            if (load_q == LOAD_LAST) begin
              state_q    <= ACK;
              cfg_load_q <= 1'b0;
              applied_q  <= 1'b1;
              epoch_q    <= epoch_q + 8'd1;
            end else begin
              load_q <= load_q + 4'd1;
            end
          end
          ACK: state_q <= WAIT_LOW;
          WAIT_LOW: begin
            if (!bus.new_cmp_config) begin
              state_q <= RUN;
              issue_q <= 1'b1;
              busy_q  <= 1'b0;
            end
          end
          default: state_q <= FAULT;
        endcase
      end
    end
  end

  assign bus.cmp_config_applied = applied_q;
  assign bus.issue_allow        = issue_q;
  assign bus.cfg_load           = cfg_load_q;
  assign bus.cfg_epoch          = epoch_q;
  assign bus.busy               = busy_q;
  assign bus.outstanding        = cnt_q;
  assign bus.error              = error_q;
endmodule

// File: tb/tb_bcrypt_cmp_apply_ctrl.sv
// Bench for bcrypt_cmp_apply_ctrl: vector table for the job counter, hand-timed
// sequences for drain/load/ack, and a queue of expected epochs per applied pulse.
module tb_bcrypt_cmp_apply_ctrl;
  localparam int CNT_W = 6;
  localparam int LC    = 4;
  localparam int DT    = 100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bcrypt_cmp_apply_ctrl_if #(.CNT_W(CNT_W)) bus ();
  bcrypt_cmp_apply_ctrl #(.CNT_W(CNT_W), .LOAD_CYCLES(LC), .DRAIN_TIMEOUT(DT)) dut (
    .clk_i(clk), .rst_i(rst), .bus(bus)
  );

  int total = 0;
  int bad = 0;
  int n_applied = 0;
  logic [7:0] exp_q[$];
  logic [7:0] m_epoch = 8'd0;

  typedef struct {
    logic issue;
    logic done;
    int   exp_out;
    logic exp_err;
  } vec_t;
  vec_t vec[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst && bus.cmp_config_applied) begin
      n_applied++;
      if (exp_q.size() == 0) chk("unexpected_applied", 32'd1, 32'd0);
      else chk("applied_epoch", {24'd0, bus.cfg_epoch}, {24'd0, exp_q.pop_front()});
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    bus.new_cmp_config = 1'b0;
    bus.job_issue = 1'b0;
    bus.job_done = 1'b0;
    bus.result_empty = 1'b1;
    step();
    step();
    exp_q.delete();
    m_epoch = 8'd0;
    rst = 1'b0;
    step();
  endtask

  task automatic finish_cfg();
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!bus.cmp_config_applied && n < 60);
    chk("apply_wait", {31'd0, bus.cmp_config_applied}, 32'd1);
    step();
    bus.new_cmp_config = 1'b0;
    n = 0;
    do begin
      step();
      n++;
    end while (!bus.issue_allow && n < 10);
    chk("issue_resume", {31'd0, bus.issue_allow}, 32'd1);
  endtask

  task automatic apply_cfg();
    m_epoch = m_epoch + 8'd1;
    exp_q.push_back(m_epoch);
    bus.new_cmp_config = 1'b1;
    finish_cfg();
  endtask

  initial begin
    int n0;
    logic early;
    bus.new_cmp_config = 1'b0;
    bus.job_issue = 1'b0;
    bus.job_done = 1'b0;
    bus.result_empty = 1'b1;

    vec[0] = '{1'b1, 1'b0, 1, 1'b0};
    vec[1] = '{1'b1, 1'b0, 2, 1'b0};
    vec[2] = '{1'b1, 1'b1, 2, 1'b0};
    vec[3] = '{1'b0, 1'b1, 1, 1'b0};
    vec[4] = '{1'b1, 1'b0, 2, 1'b0};
    vec[5] = '{1'b0, 1'b1, 1, 1'b0};
    vec[6] = '{1'b0, 1'b1, 0, 1'b0};
    vec[7] = '{1'b0, 1'b0, 0, 1'b0};
    vec[8] = '{1'b0, 1'b1, 0, 1'b1};

    // reset values
    step();
    step();
    chk("rst_busy", {31'd0, bus.busy}, 32'd1);
    chk("rst_issue", {31'd0, bus.issue_allow}, 32'd0);
    chk("rst_cfg_load", {31'd0, bus.cfg_load}, 32'd0);
    chk("rst_applied", {31'd0, bus.cmp_config_applied}, 32'd0);
    chk("rst_epoch", {24'd0, bus.cfg_epoch}, 32'd0);
    chk("rst_out", {26'd0, bus.outstanding}, 32'd0);
    chk("rst_err", {31'd0, bus.error}, 32'd0);
    rst = 1'b0;
    step();
    chk("run_busy", {31'd0, bus.busy}, 32'd0);
    chk("run_issue", {31'd0, bus.issue_allow}, 32'd1);

    // idle apply, exact cycle timing
    m_epoch = 8'd1;
    exp_q.push_back(m_epoch);
    bus.new_cmp_config = 1'b1;
    step();
    chk("t1_issue", {31'd0, bus.issue_allow}, 32'd0);
    chk("t1_busy", {31'd0, bus.busy}, 32'd1);
    chk("t1_cfg_load", {31'd0, bus.cfg_load}, 32'd0);
    for (int i = 0; i < LC; i++) begin
      step();
      chk("load_window", {31'd0, bus.cfg_load}, 32'd1);
    end
    step();
    chk("t6_cfg_load", {31'd0, bus.cfg_load}, 32'd0);
    chk("t6_applied", {31'd0, bus.cmp_config_applied}, 32'd1);
    chk("t6_epoch", {24'd0, bus.cfg_epoch}, 32'd1);
    step();
    bus.new_cmp_config = 1'b0;
    chk("t7_applied", {31'd0, bus.cmp_config_applied}, 32'd0);
    chk("t7_issue", {31'd0, bus.issue_allow}, 32'd0);
    step();
    chk("t8_issue", {31'd0, bus.issue_allow}, 32'd1);
    chk("t8_busy", {31'd0, bus.busy}, 32'd0);

    // drain with work in flight
    bus.job_issue = 1'b1;
    repeat (3) step();
    bus.job_issue = 1'b0;
    chk("three_issued", {26'd0, bus.outstanding}, 32'd3);
    m_epoch = m_epoch + 8'd1;
    exp_q.push_back(m_epoch);
    bus.new_cmp_config = 1'b1;
    early = 1'b0;
    for (int c = 0; c < 36; c++) begin
      bus.job_done = (c == 10 || c == 20 || c == 30);
      bus.result_empty = (c >= 35);
      step();
      bus.job_done = 1'b0;
      if (c < 35 && (bus.cfg_load || bus.issue_allow)) early = 1'b1;
    end
    chk("drain_no_early_load", {31'd0, early}, 32'd0);
    chk("drain_load_start", {31'd0, bus.cfg_load}, 32'd1);
    chk("drain_out_zero", {26'd0, bus.outstanding}, 32'd0);
    finish_cfg();
    chk("drain_epoch", {24'd0, bus.cfg_epoch}, 32'd2);

    // counter vectors, ending with an underflow fault
    for (int i = 0; i < 9; i++) begin
      bus.job_issue = vec[i].issue;
      bus.job_done = vec[i].done;
      step();
      bus.job_issue = 1'b0;
      bus.job_done = 1'b0;
      chk($sformatf("vec%0d_out", i), {26'd0, bus.outstanding}, vec[i].exp_out);
      chk($sformatf("vec%0d_err", i), {31'd0, bus.error}, {31'd0, vec[i].exp_err});
      chk($sformatf("vec%0d_issue", i), {31'd0, bus.issue_allow}, {31'd0, !vec[i].exp_err});
    end
    chk("uflow_busy", {31'd0, bus.busy}, 32'd1);

    // overflow saturates and faults
    do_reset();
    bus.job_issue = 1'b1;
    repeat (63) step();
    chk("max_out", {26'd0, bus.outstanding}, 32'd63);
    chk("max_err", {31'd0, bus.error}, 32'd0);
    step();
    bus.job_issue = 1'b0;
    chk("oflow_out", {26'd0, bus.outstanding}, 32'd63);
    chk("oflow_err", {31'd0, bus.error}, 32'd1);

    // drain timeout with one job stuck
    do_reset();
    bus.job_issue = 1'b1;
    step();
    bus.job_issue = 1'b0;
    chk("tmo_out", {26'd0, bus.outstanding}, 32'd1);
    bus.new_cmp_config = 1'b1;
    repeat (DT) step();
    chk("tmo_before", {31'd0, bus.error}, 32'd0);
    step();
    chk("tmo_err", {31'd0, bus.error}, 32'd1);
    chk("tmo_issue", {31'd0, bus.issue_allow}, 32'd0);
    repeat (5) step();
    chk("tmo_sticky", {31'd0, bus.error}, 32'd1);
    chk("tmo_cfg_load", {31'd0, bus.cfg_load}, 32'd0);

    // job issue while draining
    do_reset();
    bus.result_empty = 1'b0;
    bus.new_cmp_config = 1'b1;
    step();
    bus.job_issue = 1'b1;
    step();
    bus.job_issue = 1'b0;
    chk("drain_issue_err", {31'd0, bus.error}, 32'd1);
    chk("drain_issue_out", {26'd0, bus.outstanding}, 32'd1);

    // reset during the second cfg_load cycle
    do_reset();
    apply_cfg();
    chk("pre_epoch", {24'd0, bus.cfg_epoch}, 32'd1);
    bus.new_cmp_config = 1'b1;
    step();
    step();
    step();
    chk("mid_load", {31'd0, bus.cfg_load}, 32'd1);
    rst = 1'b1;
    bus.new_cmp_config = 1'b0;
    step();
    chk("rl_cfg_load", {31'd0, bus.cfg_load}, 32'd0);
    chk("rl_epoch", {24'd0, bus.cfg_epoch}, 32'd0);
    chk("rl_out", {26'd0, bus.outstanding}, 32'd0);
    chk("rl_err", {31'd0, bus.error}, 32'd0);
    chk("rl_busy", {31'd0, bus.busy}, 32'd1);
    rst = 1'b0;
    m_epoch = 8'd0;
    step();
    chk("rl_run_busy", {31'd0, bus.busy}, 32'd0);
    chk("rl_run_issue", {31'd0, bus.issue_allow}, 32'd1);

    // epoch wraps after 256 handshakes
    do_reset();
    n0 = n_applied;
    for (int i = 0; i < 256; i++) apply_cfg();
    chk("wrap_epoch", {24'd0, bus.cfg_epoch}, 32'd0);
    chk("wrap_pulses", n_applied - n0, 32'd256);

    chk("sb_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
